uart_rx_core: RTL and testbench



---
 rtl/uart_defines.sv | 37 +++
 rtl/uart_rx_sync.sv | 27 ++
 rtl/uart_rx_core.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx_core.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defines.sv
// Shared definitions for the UART receive path.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package uart_defines;

  // Record pushed into the receive FIFO: {data[7:0], break, parity_err, framing_err}
  localparam int UART_FIFO_REC_WIDTH = 11;
  localparam int UART_FIFO_COUNTER_W = 5;
  localparam int UART_TOC_W          = 10;

  // Line control register bit positions
  localparam int LCR_WLS_LO = 0;  // word length select, 0..3 -> 5..8 bits
  localparam int LCR_WLS_HI = 1;
  localparam int LCR_STB    = 2;  // two stop bits
  localparam int LCR_PEN    = 3;  // parity enable
  localparam int LCR_EPS    = 4;  // even parity select
  localparam int LCR_SP     = 5;  // stick parity

  // Flag positions inside the FIFO record
  localparam int REC_BREAK = 2;
  localparam int REC_PE    = 1;
  localparam int REC_FE    = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_e;

  // Number of data bits for a word-length select value (5..8).
  function automatic logic [3:0] word_len(input logic [1:0] wls);
    return {2'b00, wls} + 4'd5;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX pad; idles high (line-idle level).
// Latency: 2 clk from pad to q_o.
// Backpressure: none, free-running.
// Ports: clk/rst_n clock and async active-low reset; d_i async input; q_o synchronised output.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/uart_rx_core.sv
// UART receive front end: start detect, 16x-oversampled deserialise, parity/stop check, char timeout.
// Latency: record pushed 1 clk after the stop-bit sample tick (8N1: tick T+151 after the start edge).
// Backpressure: none; rf_push is a one-clk strobe, the FIFO must accept or drop it.
// Ports: clk, rst_n; enable 16x tick; srx_pad_i async RX line; lcr line control;
//        rf_count/rf_pop FIFO fill and pop strobe; rf_data_in/rf_push record and push strobe;
//        rx_idle receiver idle; timeout_o character timeout.
module uart_rx_core
  import uart_defines::*;
#(
  parameter int fifo_width     = UART_FIFO_REC_WIDTH,
  parameter int fifo_counter_w = UART_FIFO_COUNTER_W,
  parameter int toc_w          = UART_TOC_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      srx_pad_i,
  input  logic [7:0]                lcr,
  input  logic [fifo_counter_w-1:0] rf_count,
  input  logic                      rf_pop,
  output logic [fifo_width-1:0]     rf_data_in,
  output logic                      rf_push,
  output logic                      rx_idle,
  output logic                      timeout_o
);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (srx_pad_i),
    .q_o   (rx_s)
  );

  rx_state_e             state_q, state_d;
  logic                  armed_q, armed_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            data_q, data_d;
  logic                  par_err_q, par_err_d;
  logic                  par_bit_q, par_bit_d;
  logic [5:0]            lcr_q, lcr_d;
  logic [fifo_width-1:0] rf_data_q, rf_data_d;
  logic                  rf_push_q, rf_push_d;
  logic [toc_w-1:0]      toc_q, toc_d;
  logic                  timeout_q, timeout_d;

  // lcr[7:6] belong to other UART blocks.
  logic unused_lcr;
  assign unused_lcr = ^lcr[7:6];

  // Character framing taken from the copy latched at the start edge.
  logic [2:0] last_bit;
  logic       pen;
  logic       exp_par;
  logic       brk;

  assign last_bit = {1'b0, lcr_q[LCR_WLS_HI:LCR_WLS_LO]} + 3'd4;
  assign pen      = lcr_q[LCR_PEN];
  assign exp_par  = lcr_q[LCR_SP] ? ~lcr_q[LCR_EPS]
                  : (lcr_q[LCR_EPS] ? ^data_q : ~^data_q);
  // par_bit_q stays 0 when parity is disabled, so it only vetoes a break when a 1 was seen.
  assign brk      = (data_q == 8'h00) && !par_bit_q && !rx_s;

  // Timeout threshold follows the live lcr: four characters of 16 ticks per bit.
  logic [3:0]       char_bits;
  logic [toc_w-1:0] toc_value;

  assign char_bits = 4'd2 + word_len(lcr[LCR_WLS_HI:LCR_WLS_LO])
                   + {3'b000, lcr[LCR_PEN]} + {3'b000, lcr[LCR_STB]};
  assign toc_value = toc_w'({char_bits, 6'b000000});

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    data_d    = data_q;
    par_err_d = par_err_q;
    par_bit_d = par_bit_q;
    lcr_d     = lcr_q;
    rf_data_d = rf_data_q;
    rf_push_d = 1'b0;

    if (enable) begin
      unique case (state_q)
        S_IDLE: begin
          // armed only sets here, so a break or framing error that leaves the
          // line low cannot restart until the line has been seen high again.
          if (rx_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            armed_d   = 1'b0;
            lcr_d     = lcr[5:0];
            cnt_d     = 4'd0;
            bit_d     = 3'd0;
            data_d    = 8'h00;
            par_err_d = 1'b0;
            par_bit_d = 1'b0;
            state_d   = S_START;
          end
        end
        S_START: begin
          cnt_d = cnt_q + 4'd1;
          // cnt_q==6 is tick T+7, the middle of the start bit.
          if (cnt_q == 4'd6) begin
            cnt_d   = 4'd0;
            state_d = rx_s ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          // cnt wraps 15->0, so every later sample lands 16 ticks apart.
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            data_d[bit_q] = rx_s;
            bit_d         = bit_q + 3'd1;
            if (bit_q == last_bit) begin
              state_d = pen ? S_PARITY : S_STOP;
            end
          end
        end
        S_PARITY: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            par_bit_d = rx_s;
            par_err_d = (rx_s != exp_par);
            state_d   = S_STOP;
          end
        end
        S_STOP: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            // Only the first stop bit is checked; a second one is left to idle.
            rf_data_d = fifo_width'({data_q, brk, par_err_q, ~rx_s});
            rf_push_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    toc_d = toc_q;
    if ((rf_count == '0) || rf_push_q || rf_pop) begin
      toc_d = '0;
    end else if (enable && (toc_q < toc_value)) begin
      toc_d = toc_q + 1'b1;
    end
    timeout_d = (toc_d == toc_value);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      armed_q   <= 1'b0;
      cnt_q     <= 4'd0;
      bit_q     <= 3'd0;
      data_q    <= 8'h00;
      par_err_q <= 1'b0;
      par_bit_q <= 1'b0;
      lcr_q     <= 6'd0;
      rf_data_q <= '0;
      rf_push_q <= 1'b0;
      toc_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      par_err_q <= par_err_d;
      par_bit_q <= par_bit_d;
      lcr_q     <= lcr_d;
      rf_data_q <= rf_data_d;
      rf_push_q <= rf_push_d;
      toc_q     <= toc_d;
      timeout_q <= timeout_d;
    end
  end

  assign rf_data_in = rf_data_q;
  assign rf_push    = rf_push_q;
  assign rx_idle    = (state_q == S_IDLE);
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboarded bench for uart_rx_core: directed characters, break, glitch, timeout, reset.
// Latency: push tick checked against hand-computed T+lat values.
// Backpressure: n/a.
module tb_uart_rx_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        srx_pad_i;
  logic [7:0]  lcr;
  logic [4:0]  rf_count;
  logic        rf_pop;
  logic [10:0] rf_data_in;
  logic        rf_push;
  logic        rx_idle;
  logic        timeout_o;

  uart_rx_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .srx_pad_i  (srx_pad_i),
    .lcr        (lcr),
    .rf_count   (rf_count),
    .rf_pop     (rf_pop),
    .rf_data_in (rf_data_in),
    .rf_push    (rf_push),
    .rx_idle    (rx_idle),
    .timeout_o  (timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] rec;
    int          tick;   // expected tick count at push, -1 = not checked
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   tick_cnt = 0;
  int   div      = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // 16x tick: one clk wide every 4 clks, changed on the falling edge.
  initial begin
    enable = 1'b0;
    forever begin
      @(negedge clk);
      div    = (div + 1) % 4;
      enable = (div == 0);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (enable) tick_cnt++;
    end
  end

  // Monitor: pops the scoreboard on every push, and checks the strobe is one clk wide.
  initial begin
    exp_t e;
    bit   prev_push;
    prev_push = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (prev_push) check("push_one_clk", {31'd0, rf_push}, 32'd0);
        if (rf_push === 1'b1) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_push: got record 0x%0h, expected no push", rf_data_in);
          end else begin
            e = sb_q.pop_front();
            check("record", {21'd0, rf_data_in}, {21'd0, e.rec});
            if (e.tick >= 0) check("push_tick", tick_cnt, e.tick);
          end
        end
        prev_push = (rf_push === 1'b1);
      end else begin
        prev_push = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  // Waits n tick edges, returning 1 time unit after the last one.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!enable) @(posedge clk);
    end
    #1;
  endtask

  // Drives one character bit-cell by bit-cell; called just after a tick.
  // lat = ticks from the start edge T to the push, or -1.
  task automatic send_char(input logic [7:0] d, input int nbits, input bit pe, input bit pbit,
                           input bit stop1, input logic [10:0] rec, input int lat);
    exp_t e;
    e.rec  = rec;
    e.tick = (lat < 0) ? -1 : tick_cnt + 1 + lat;
    sb_q.push_back(e);
    srx_pad_i = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < nbits; i++) begin
      srx_pad_i = d[i];
      wait_ticks(16);
    end
    if (pe) begin
      srx_pad_i = pbit;
      wait_ticks(16);
    end
    srx_pad_i = stop1;
    wait_ticks(16);
    srx_pad_i = 1'b1;
    wait_ticks(24);
  endtask

  initial begin
    exp_t e;
    rst_n     = 1'b0;
    srx_pad_i = 1'b1;
    lcr       = 8'h03;
    rf_count  = 5'd0;
    rf_pop    = 1'b0;
    #1;
    check("rst_rf_data_in", {21'd0, rf_data_in}, 32'd0);
    check("rst_rf_push",    {31'd0, rf_push},    32'd0);
    check("rst_rx_idle",    {31'd0, rx_idle},    32'd1);
    check("rst_timeout",    {31'd0, timeout_o},  32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(4);

    // 8N1 0xA5: push at T+151
    lcr = 8'h03;
    send_char(8'hA5, 8, 1'b0, 1'b0, 1'b1, {8'hA5, 3'b000}, 151);

    // 7E1 0x41 (two ones -> even parity bit 0): parity 1 is an error, parity 0 is clean
    lcr = 8'h1A;
    send_char(8'h41, 7, 1'b1, 1'b1, 1'b1, {8'h41, 3'b010}, 151);
    send_char(8'h41, 7, 1'b1, 1'b0, 1'b1, {8'h41, 3'b000}, 151);

    // 5N2 0x1F with a low first stop bit: framing error, push at T+7+16*6
    lcr = 8'h04;
    send_char(8'h1F, 5, 1'b0, 1'b0, 1'b0, {8'h1F, 3'b001}, 103);
    wait_ticks(40);
    check("idle_after_fe", {31'd0, rx_idle}, 32'd1);

    // Line held low for three 8N1 character times: exactly one break record
    lcr = 8'h03;
    e.rec  = {8'h00, 3'b101};
    e.tick = tick_cnt + 1 + 151;
    sb_q.push_back(e);
    srx_pad_i = 1'b0;
    wait_ticks(480);
    check("idle_during_break", {31'd0, rx_idle}, 32'd1);
    srx_pad_i = 1'b1;
    wait_ticks(24);
    send_char(8'h55, 8, 1'b0, 1'b0, 1'b1, {8'h55, 3'b000}, 151);

    // 4-tick low glitch: false start, back to idle at T+7
    srx_pad_i = 1'b0;
    wait_ticks(4);
    srx_pad_i = 1'b1;
    check("glitch_busy_T3", {31'd0, rx_idle}, 32'd0);
    wait_ticks(3);
    check("glitch_busy_T6", {31'd0, rx_idle}, 32'd0);
    wait_ticks(1);
    check("glitch_idle_T7", {31'd0, rx_idle}, 32'd1);
    wait_ticks(20);

    // Timeout: 8N1 -> 10 bits * 64 = 640 ticks
    rf_count = 5'd3;
    wait_ticks(639);
    check("toc_before_640", {31'd0, timeout_o}, 32'd0);
    wait_ticks(1);
    check("toc_at_640", {31'd0, timeout_o}, 32'd1);
    @(negedge clk);
    rf_pop = 1'b1;
    @(posedge clk);
    #1;
    rf_pop = 1'b0;
    check("toc_pop_clear", {31'd0, timeout_o}, 32'd0);
    wait_ticks(639);
    check("toc_restart_639", {31'd0, timeout_o}, 32'd0);
    wait_ticks(1);
    check("toc_restart_640", {31'd0, timeout_o}, 32'd1);

    // Reset in the middle of the data bits
    srx_pad_i = 1'b0;
    wait_ticks(40);
    check("busy_before_rst", {31'd0, rx_idle}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rf_data_in", {21'd0, rf_data_in}, 32'd0);
    check("mid_rst_rf_push",    {31'd0, rf_push},    32'd0);
    check("mid_rst_rx_idle",    {31'd0, rx_idle},    32'd1);
    check("mid_rst_timeout",    {31'd0, timeout_o},  32'd0);
    srx_pad_i = 1'b1;
    rf_count  = 5'd0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(4);
    send_char(8'h3C, 8, 1'b0, 1'b0, 1'b1, {8'h3C, 3'b000}, 151);

    wait_ticks(20);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
